mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Load/store stage directly downstream of the execute stage.
//  - Consumes the ALU result (address), the propagated rs2 value and the propagated funct3.
//  - Runs one data-memory transaction over a req/ack handshake.
//  - Returns sign/zero-extended load data and a one-cycle done pulse that lets the core retire.
// PARAMETERS
//  XLEN      32  datapath width; only 32 is supported (4 byte lanes)
//  TIMEOUT   16  max REQ cycles waiting for dmem_ack before bus error; 0 = wait forever
// PORTS
//  clk         in   1       core clock, rising edge
//  rst         in   1       asynchronous, active-high reset
//  start       in   1       EX result valid; sampled only in IDLE
//  is_load     in   1       op is a load
//  is_store    in   1       op is a store (is_load && is_store is illegal: error)
//  addr        in   XLEN    byte address (ALU result)
//  store_data  in   XLEN    propagated rs2 value
//  funct3      in   3       000 B, 001 H, 010 W, 100 BU, 101 HU
//  busy        out  1       high in every state except IDLE
//  done        out  1       one-cycle completion pulse
//  load_data   out  XLEN    extended load result; valid with done, held until next done
//  err         out  1       valid with done: illegal op/funct3, timeout, or misaligned
//  misaligned  out  1       valid with done; constant 0 unless MISALIGN_TRAP_EN
//  dmem_req    out  1       request; held high until ack
//  dmem_we     out  1       1 = write
//  dmem_addr   out  XLEN    word-aligned address {addr[XLEN-1:2],2'b00}
//  dmem_wdata  out  XLEN    lane-replicated store data
//  dmem_be     out  4       byte enables (loads drive the accessed lanes as well)
//  dmem_ack    in   1       memory completion; rdata valid in the same cycle
//  dmem_rdata  in   XLEN    read word
// BEHAVIOUR
//  Reset: state IDLE; every output 0, including load_data. Reset mid-REQ drops dmem_req
//   asynchronously and abandons the access; memory must tolerate the abandoned request.
//  FSM:
//   - IDLE -> REQ on start with exactly one of is_load/is_store and a legal funct3.
//     Stores accept only funct3 000/001/010.
//   - IDLE -> DONE on start with no memory op (err=0, load_data unchanged).
//   - IDLE -> DONE on start with an illegal op/funct3 (err=1, no request issued).
//   - REQ: dmem_req=1; bus outputs registered at entry and stable until ack.
//     On dmem_ack -> DONE. A load captures the extended rdata at this point.
//   - DONE: done=1 for one cycle -> IDLE.
//  Latency: start sampled at cycle N -> REQ at N+1. Ack at N+1+k -> done at N+2+k.
//   Non-memory op: done at N+1.
//  Handshake:
//   - start is ignored while busy.
//   - dmem_ack outside REQ is ignored.
//   - Ack on the first REQ cycle is legal (zero wait).
//  Timeout: wait counter resets on REQ entry. If TIMEOUT>0 and TIMEOUT cycles pass
//   without ack -> DONE with err=1, dmem_req dropped, load_data unchanged.
//  Lanes: o = addr[1:0].
//   - B: be = 1<<o; wdata = {4{sd[7:0]}}.
//   - H: be = 2'b11<<o; wdata = {2{sd[15:0]}}.
//   - W: be = 4'hF.
//   - Load: the selected byte/half is taken from rdata lane o, then sign-extended
//     (B/H) or zero-extended (BU/HU).
// CONFIGURATION
//  MISALIGN_TRAP_EN defined:
//   - H with addr[0]=1 or W with addr[1:0]!=0 issues no request.
//   - DONE follows the next cycle with err=1 and misaligned=1.
//  MISALIGN_TRAP_EN undefined:
//   - Low address bits are forced to natural alignment (H: o[0]=0; W: o=0).
//   - No fault; misaligned tied 0.
// TESTING
//  1. SW addr=0x104, sd=0xDEADBEEF, ack after 2 cycles:
//     dmem_addr=0x104, be=F, wdata=0xDEADBEEF, we=1; done 4 cycles after start, err=0.
//  2. LB addr=0x203, rdata=0x80FF7F01 -> load_data=0xFFFFFF80.
//     LBU with the same stimulus -> 0x00000080.
//  3. SH addr=0x12, sd=0x0000ABCD -> be=4'b1100, wdata=0xABCDABCD.
//     LHU addr=0x12, rdata=0x1234ABCD -> 0x00001234.
//  4. LW with dmem_ack never asserted, TIMEOUT=16 ->
//     dmem_req high exactly 16 cycles, then done with err=1.
//  5. LH addr=0x101: with MISALIGN_TRAP_EN -> no dmem_req, done next cycle, err=1, misaligned=1.
//     Without it -> access at 0x100, be=4'b0011, err=0.
//  6. rst asserted mid-REQ -> dmem_req/busy drop with no clock edge.
//     start pulsed while busy -> ignored, exactly one done per accepted start.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store stage: runs one data-memory transaction per accepted EX result and returns extended load data.
// Optional build macro MISALIGN_TRAP_EN turns misaligned H/W accesses into error completions instead of forced alignment.
module mem_access_unit #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            is_load,
  input  logic            is_store,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  input  logic [2:0]      funct3,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] load_data,
  output logic            err,
  output logic            misaligned,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata
);

  // Handshake: dmem_req rises with the registered bus fields and stays high with them frozen
  // until the cycle dmem_ack is sampled high (or the wait budget runs out); ack elsewhere is ignored.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t          state;
  logic [CW-1:0]   wait_cnt;
  logic [2:0]      ld_f3;
  logic [1:0]      ld_off;

  logic            one_op;
  logic            op_ok;
  logic            mis_c;
  logic [1:0]      off_c;
  logic [3:0]      be_c;
  logic [XLEN-1:0] wdata_c;
  logic [XLEN-1:0] lane;
  logic [XLEN-1:0] ext;

  assign one_op = is_load ^ is_store;

  always_comb begin
    op_ok = 1'b0;
    if (is_load)
      op_ok = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    else if (is_store)
      op_ok = funct3 inside {3'b000, 3'b001, 3'b010};
  end

`ifdef MISALIGN_TRAP_EN
  assign mis_c = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
  assign mis_c = 1'b0;
`endif

  // Halves and words are snapped to their natural lane; with the trap enabled they never get here misaligned.
  always_comb begin
    off_c   = addr[1:0];
    be_c    = 4'hF;
    wdata_c = store_data;
    case (funct3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << off_c;
        wdata_c = {4{store_data[7:0]}};
      end
      2'b01: begin
        off_c   = {addr[1], 1'b0};
        be_c    = 4'b0011 << off_c;
        wdata_c = {2{store_data[15:0]}};
      end
      default: begin
        off_c   = 2'b00;
        be_c    = 4'hF;
        wdata_c = store_data;
      end
    endcase
  end

  assign lane = dmem_rdata >> {ld_off, 3'b000};

  always_comb begin
    case (ld_f3)
      3'b000:  ext = {{(XLEN-8){lane[7]}}, lane[7:0]};
      3'b001:  ext = {{(XLEN-16){lane[15]}}, lane[15:0]};
      3'b100:  ext = {{(XLEN-8){1'b0}}, lane[7:0]};
      3'b101:  ext = {{(XLEN-16){1'b0}}, lane[15:0]};
      default: ext = lane;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      ld_f3      <= 3'b000;
      ld_off     <= 2'b00;
      busy       <= 1'b0;
      done       <= 1'b0;
      load_data  <= '0;
      err        <= 1'b0;
      misaligned <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= 4'h0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (!is_load && !is_store) begin
              state      <= DONE;
              done       <= 1'b1;
              err        <= 1'b0;
              misaligned <= 1'b0;
            end else if (!one_op || !op_ok) begin
              state      <= DONE;
              done       <= 1'b1;
              err        <= 1'b1;
              misaligned <= 1'b0;
            end else if (mis_c) begin
              state      <= DONE;
              done       <= 1'b1;
              err        <= 1'b1;
              misaligned <= 1'b1;
            end else begin
              state      <= REQ;
              wait_cnt   <= '0;
              ld_f3      <= funct3;
              ld_off     <= off_c;
              dmem_req   <= 1'b1;
              dmem_we    <= is_store;
              dmem_addr  <= {addr[XLEN-1:2], 2'b00};
              dmem_wdata <= wdata_c;
              dmem_be    <= be_c;
            end
          end
        end
        REQ: begin
          if (dmem_ack) begin
            state      <= DONE;
            done       <= 1'b1;
            dmem_req   <= 1'b0;
            err        <= 1'b0;
            misaligned <= 1'b0;
            if (!dmem_we)
              load_data <= ext;
          end else if ((TIMEOUT > 0) && (wait_cnt == LAST)) begin
            state      <= DONE;
            done       <= 1'b1;
            dmem_req   <= 1'b0;
            err        <= 1'b1;
            misaligned <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized traffic against a lane-arithmetic model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_load;
  logic        is_store;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [2:0]  funct3;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic        err;
  logic        misaligned;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  mem_access_unit #(.XLEN(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .is_load(is_load), .is_store(is_store),
    .addr(addr), .store_data(store_data), .funct3(funct3), .busy(busy), .done(done),
    .load_data(load_data), .err(err), .misaligned(misaligned), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ld_model;

  int          obs_lat;
  int          obs_req;
  logic        obs_done;
  logic        obs_unstable;
  logic        obs_busy_gap;
  logic        obs_err;
  logic        obs_mis;
  logic [31:0] obs_ld;
  logic [31:0] obs_addr;
  logic [31:0] obs_wdata;
  logic [3:0]  obs_be;
  logic        obs_we;

  typedef struct packed {
    logic        req;
    logic        we;
    logic        err;
    logic        mis;
    logic [1:0]  off;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;

  // Access rules expressed as byte counts and offsets rather than lane muxes.
  function automatic exp_t model(input logic ld, input logic st, input logic [31:0] a,
                                 input logic [31:0] sd, input logic [2:0] f3);
    exp_t e;
    int size;
    int off;
    e = '0;
    if (!ld && !st) return e;
    case (f3[1:0])
      2'b00:   size = 1;
      2'b01:   size = 2;
      2'b10:   size = 4;
      default: size = 0;
    endcase
    if ((ld && st) || size == 0 || (f3[2] && (st || size == 4))) begin
      e.err = 1'b1;
      return e;
    end
    off = int'(a % 32'd4);
    if (off % size != 0) begin
`ifdef MISALIGN_TRAP_EN
      e.err = 1'b1;
      e.mis = 1'b1;
      return e;
`else
      off = off - off % size;
`endif
    end
    e.req  = 1'b1;
    e.we   = st;
    e.addr = a - (a % 32'd4);
    e.off  = 2'(off);
    e.be   = 4'(((1 << size) - 1) << off);
    for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = sd[8*(i % size) +: 8];
    return e;
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] f3, input int off, input logic [31:0] rdata);
    longint v;
    int bits;
    bits = (f3[1:0] == 2'b00) ? 8 : (f3[1:0] == 2'b01) ? 16 : 32;
    v = longint'(rdata) >> (8 * off);
    v = v % (64'sd1 << bits);
    if (!f3[2] && bits < 32 && v >= (64'sd1 << (bits - 1))) v = v - (64'sd1 << bits);
    return v[31:0];
  endfunction

  // Drives one start, plays the memory side, and records what the DUT did until done (bounded).
  task automatic run_op(input logic ld, input logic st, input logic [31:0] a, input logic [31:0] sd,
                        input logic [2:0] f3, input int ack_delay, input logic [31:0] rdata, input bit noise);
    @(negedge clk);
    start = 1'b1; is_load = ld; is_store = st; addr = a; store_data = sd; funct3 = f3;
    dmem_rdata = rdata;
    dmem_ack = 1'($urandom_range(0, 1));
    obs_lat = 0; obs_req = 0; obs_unstable = 1'b0; obs_busy_gap = 1'b0;
    obs_addr = '0; obs_wdata = '0; obs_be = '0; obs_we = 1'b0;
    @(negedge clk);
    obs_lat = 1;
    start = 1'b0;
    while (!done && obs_lat < 100) begin
      if (!busy) obs_busy_gap = 1'b1;
      if (dmem_req) begin
        if (obs_req == 0) begin
          obs_addr = dmem_addr; obs_wdata = dmem_wdata; obs_be = dmem_be; obs_we = dmem_we;
        end else if ({dmem_addr, dmem_wdata, dmem_be, dmem_we} !== {obs_addr, obs_wdata, obs_be, obs_we}) begin
          obs_unstable = 1'b1;
        end
        dmem_ack = (obs_req == ack_delay);
        obs_req++;
      end else begin
        dmem_ack = 1'b0;
      end
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        is_load = 1'($urandom_range(0, 1));
        is_store = 1'($urandom_range(0, 1));
        addr = $urandom;
        store_data = $urandom;
        funct3 = 3'($urandom_range(0, 7));
      end
      @(negedge clk);
      obs_lat++;
    end
    obs_done = done;
    obs_err = err;
    obs_mis = misaligned;
    obs_ld = load_data;
    start = 1'b0;
    dmem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; is_load = 1'b0; is_store = 1'b0; addr = '0; store_data = '0;
    funct3 = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, load_data, err, misaligned, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b ld=%h err=%b mis=%b req=%b we=%b a=%h wd=%h be=%h expected all 0",
               busy, done, load_data, err, misaligned, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be);
    end
    rst = 1'b0;
    ld_model = '0;
    @(negedge clk);
    checks++;
    if ({busy, done, dmem_req} !== 3'b000) begin
      errors++;
      $display("FAIL reset_release: got busy=%b done=%b req=%b expected 000", busy, done, dmem_req);
    end
  endtask

  task automatic test_store_word();
    run_op(1'b0, 1'b1, 32'h104, 32'hDEADBEEF, 3'b010, 2, 32'h0, 1'b0);
    checks++;
    if (obs_addr !== 32'h104) begin errors++; $display("FAIL sw_addr: got %h expected %h", obs_addr, 32'h104); end
    checks++;
    if (obs_be !== 4'hF) begin errors++; $display("FAIL sw_be: got %h expected F", obs_be); end
    checks++;
    if (obs_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_wdata: got %h expected DEADBEEF", obs_wdata); end
    checks++;
    if (obs_we !== 1'b1) begin errors++; $display("FAIL sw_we: got %b expected 1", obs_we); end
    checks++;
    if (!obs_done || obs_lat != 4) begin errors++; $display("FAIL sw_latency: got done=%b lat=%0d expected 4", obs_done, obs_lat); end
    checks++;
    if (obs_err !== 1'b0) begin errors++; $display("FAIL sw_err: got %b expected 0", obs_err); end
    checks++;
    if (obs_req != 3 || obs_unstable || obs_busy_gap) begin
      errors++;
      $display("FAIL sw_req: got req_cycles=%0d unstable=%b busy_gap=%b expected 3/0/0", obs_req, obs_unstable, obs_busy_gap);
    end
  endtask

  task automatic test_load_byte();
    run_op(1'b1, 1'b0, 32'h203, 32'h0, 3'b000, 1, 32'h80FF7F01, 1'b0);
    checks++;
    if (obs_ld !== 32'hFFFFFF80 || obs_err !== 1'b0) begin
      errors++; $display("FAIL lb_data: got %h err=%b expected FFFFFF80 err=0", obs_ld, obs_err);
    end
    checks++;
    if (obs_addr !== 32'h200 || obs_be !== 4'b1000 || obs_we !== 1'b0) begin
      errors++; $display("FAIL lb_bus: got a=%h be=%b we=%b expected 200/1000/0", obs_addr, obs_be, obs_we);
    end
    run_op(1'b1, 1'b0, 32'h203, 32'h0, 3'b100, 0, 32'h80FF7F01, 1'b0);
    checks++;
    if (obs_ld !== 32'h00000080) begin errors++; $display("FAIL lbu_data: got %h expected 00000080", obs_ld); end
    checks++;
    if (obs_lat != 2) begin errors++; $display("FAIL lbu_zero_wait: got lat=%0d expected 2", obs_lat); end
    ld_model = 32'h00000080;
  endtask

  task automatic test_half();
    run_op(1'b0, 1'b1, 32'h12, 32'h0000ABCD, 3'b001, 0, 32'h0, 1'b0);
    checks++;
    if (obs_be !== 4'b1100 || obs_wdata !== 32'hABCDABCD) begin
      errors++; $display("FAIL sh_lanes: got be=%b wd=%h expected 1100/ABCDABCD", obs_be, obs_wdata);
    end
    checks++;
    if (obs_ld !== ld_model) begin errors++; $display("FAIL sh_ld_hold: got %h expected %h", obs_ld, ld_model); end
    run_op(1'b1, 1'b0, 32'h12, 32'h0, 3'b101, 3, 32'h1234ABCD, 1'b0);
    checks++;
    if (obs_ld !== 32'h00001234) begin errors++; $display("FAIL lhu_data: got %h expected 00001234", obs_ld); end
    ld_model = 32'h00001234;
  endtask

  task automatic test_timeout();
    run_op(1'b1, 1'b0, 32'h80, 32'h0, 3'b010, -1, 32'hCAFEF00D, 1'b0);
    checks++;
    if (obs_req != 16) begin errors++; $display("FAIL to_req_cycles: got %0d expected 16", obs_req); end
    checks++;
    if (!obs_done || obs_lat != 17 || obs_err !== 1'b1) begin
      errors++; $display("FAIL to_done: got done=%b lat=%0d err=%b expected 1/17/1", obs_done, obs_lat, obs_err);
    end
    checks++;
    if (obs_ld !== ld_model) begin errors++; $display("FAIL to_ld_hold: got %h expected %h", obs_ld, ld_model); end
  endtask

  task automatic test_misaligned();
    run_op(1'b1, 1'b0, 32'h101, 32'h0, 3'b001, 1, 32'h5555AAAA, 1'b0);
`ifdef MISALIGN_TRAP_EN
    checks++;
    if (obs_req != 0 || obs_lat != 1) begin
      errors++; $display("FAIL mis_trap_noreq: got req=%0d lat=%0d expected 0/1", obs_req, obs_lat);
    end
    checks++;
    if (obs_err !== 1'b1 || obs_mis !== 1'b1 || obs_ld !== ld_model) begin
      errors++; $display("FAIL mis_trap_flags: got err=%b mis=%b ld=%h expected 1/1/%h", obs_err, obs_mis, obs_ld, ld_model);
    end
`else
    checks++;
    if (obs_addr !== 32'h100 || obs_be !== 4'b0011) begin
      errors++; $display("FAIL mis_align: got a=%h be=%b expected 100/0011", obs_addr, obs_be);
    end
    checks++;
    if (obs_err !== 1'b0 || obs_mis !== 1'b0 || obs_ld !== 32'hFFFFAAAA) begin
      errors++; $display("FAIL mis_align_data: got err=%b mis=%b ld=%h expected 0/0/FFFFAAAA", obs_err, obs_mis, obs_ld);
    end
    ld_model = 32'hFFFFAAAA;
`endif
  endtask

  task automatic test_illegal();
    logic [5:0] tab [6] = '{6'b01_100_1, 6'b11_010_1, 6'b10_011_1, 6'b00_010_0, 6'b10_110_1, 6'b01_101_1};
    for (int i = 0; i < 6; i++) begin
      run_op(tab[i][5], tab[i][4], $urandom, $urandom, tab[i][3:1], 0, $urandom, 1'b0);
      checks++;
      if (obs_req != 0 || obs_lat != 1 || obs_err !== tab[i][0] || obs_mis !== 1'b0 || obs_ld !== ld_model) begin
        errors++;
        $display("FAIL illegal_%0d: got req=%0d lat=%0d err=%b mis=%b ld=%h expected 0/1/%b/0/%h",
                 i, obs_req, obs_lat, obs_err, obs_mis, obs_ld, tab[i][0], ld_model);
      end
    end
  endtask

  task automatic test_reset_mid_req();
    @(negedge clk);
    start = 1'b1; is_load = 1'b1; is_store = 1'b0; addr = 32'h40; funct3 = 3'b010; dmem_ack = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (dmem_req !== 1'b1) begin errors++; $display("FAIL rstreq_pre: got req=%b expected 1", dmem_req); end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rstreq_async: got req=%b busy=%b expected 0/0", dmem_req, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    ld_model = '0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || load_data !== 32'h0 || busy !== 1'b0) begin
      errors++; $display("FAIL rstreq_after: got done=%b ld=%h busy=%b expected 0/0/0", done, load_data, busy);
    end
  endtask

  task automatic test_start_while_busy();
    int extra;
    run_op(1'b1, 1'b0, 32'h3C, 32'h0, 3'b010, 4, 32'h13579BDF, 1'b1);
    checks++;
    if (obs_ld !== 32'h13579BDF || obs_lat != 6 || obs_addr !== 32'h3C) begin
      errors++; $display("FAIL busy_ignore: got ld=%h lat=%0d a=%h expected 13579BDF/6/3C", obs_ld, obs_lat, obs_addr);
    end
    ld_model = 32'h13579BDF;
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) extra++;
    end
    checks++;
    if (extra != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL busy_one_done: got extra_done=%0d busy=%b expected 0/0", extra, busy);
    end
  endtask

  task automatic test_random();
    logic [2:0] legal [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    repeat (60) begin
      int r;
      int delay;
      logic ld, st;
      logic [2:0] f3;
      logic [31:0] a, sd, rd, exp_ld;
      exp_t e;
      r = $urandom_range(0, 9);
      ld = (r == 1) || (r >= 2 && r < 6);
      st = (r == 1) || (r >= 6);
      f3 = ($urandom_range(0, 3) != 0) ? legal[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
      a = $urandom; sd = $urandom; rd = $urandom;
      delay = $urandom_range(0, 4);
      e = model(ld, st, a, sd, f3);
      if (e.req && ld) exp_q.push_back(load_val(f3, int'(e.off), rd));
      else exp_q.push_back(ld_model);
      run_op(ld, st, a, sd, f3, delay, rd, 1'b1);
      exp_ld = exp_q.pop_front();
      ld_model = exp_ld;
      checks++;
      if (!obs_done || obs_lat != (e.req ? delay + 2 : 1) || obs_req != (e.req ? delay + 1 : 0)) begin
        errors++;
        $display("FAIL rnd_timing: got done=%b lat=%0d req=%0d expected lat=%0d req=%0d (ld=%b st=%b f3=%b a=%h)",
                 obs_done, obs_lat, obs_req, e.req ? delay + 2 : 1, e.req ? delay + 1 : 0, ld, st, f3, a);
      end
      checks++;
      if (obs_err !== e.err || obs_mis !== e.mis || obs_ld !== exp_ld) begin
        errors++;
        $display("FAIL rnd_result: got err=%b mis=%b ld=%h expected %b/%b/%h (ld=%b st=%b f3=%b a=%h rd=%h)",
                 obs_err, obs_mis, obs_ld, e.err, e.mis, exp_ld, ld, st, f3, a, rd);
      end
      if (e.req) begin
        checks++;
        if (obs_addr !== e.addr || obs_be !== e.be || obs_we !== e.we || (st && obs_wdata !== e.wdata) ||
            obs_unstable || obs_busy_gap) begin
          errors++;
          $display("FAIL rnd_bus: got a=%h be=%b we=%b wd=%h unst=%b gap=%b expected %h/%b/%b/%h (f3=%b sd=%h)",
                   obs_addr, obs_be, obs_we, obs_wdata, obs_unstable, obs_busy_gap,
                   e.addr, e.be, e.we, e.wdata, f3, sd);
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_store_word();
    test_load_byte();
    test_half();
    test_timeout();
    test_misaligned();
    test_illegal();
    test_reset_mid_req();
    test_start_while_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
